regfile_scoreboard: RTL and testbench

Parametrised integer register file for the pipelined RISC-V core, with write-port-to-read-port bypass and a per-register busy scoreboard. It replaces the single-cycle register file in the decode stage. Two combinational read ports, one synchronous write port, and an issue port track in-flight destination registers. The block raises `issue_ready` only when the decoding instruction has no RAW or WAW hazard.

---
 rtl/regfile_scoreboard.sv | 100 ++++++++++
 tb/tb_regfile_scoreboard.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with writeback-to-read bypass and a per-register busy
// scoreboard that gates instruction issue on RAW/WAW hazards.
module regfile_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_sel_in,
  input  logic [ADDR_W-1:0] rs2_sel_in,
  input  logic              rs1_en,
  input  logic              rs2_en,
  output logic [DATA_W-1:0] rs1_value_out,
  output logic [DATA_W-1:0] rs2_value_out,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              issue_valid,
  input  logic              issue_rd_en,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] rd_sel_in,
  input  logic [DATA_W-1:0] write_data_in,
  input  logic              flush
);

  localparam int unsigned NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;

  logic wr_active;
  logic rs1_fwd, rs2_fwd, rd_fwd;
  logic rd_busy;
  logic raw, waw;
  logic issue_accept;

  assign wr_active = write_enable && (rd_sel_in != '0);

  // Forward match only exists with bypass; it also exempts busy, so without
  // bypass a register reads busy until the cycle after its writeback.
  assign rs1_fwd = BYPASS && write_enable && (rd_sel_in == rs1_sel_in);
  assign rs2_fwd = BYPASS && write_enable && (rd_sel_in == rs2_sel_in);
  assign rd_fwd  = BYPASS && write_enable && (rd_sel_in == issue_rd);

  always_comb begin
    rs1_value_out = '0;
    if (rs1_sel_in != '0) begin
      rs1_value_out = rs1_fwd ? write_data_in : regs[rs1_sel_in];
    end
  end

  always_comb begin
    rs2_value_out = '0;
    if (rs2_sel_in != '0) begin
      rs2_value_out = rs2_fwd ? write_data_in : regs[rs2_sel_in];
    end
  end

  assign rs1_busy = busy[rs1_sel_in] && !rs1_fwd;
  assign rs2_busy = busy[rs2_sel_in] && !rs2_fwd;
  assign rd_busy  = busy[issue_rd]   && !rd_fwd;

  assign raw          = (rs1_en && rs1_busy) || (rs2_en && rs2_busy);
  assign waw          = issue_rd_en && rd_busy;
  assign issue_ready  = !raw && !waw && !flush;
  assign issue_accept = issue_valid && issue_ready;

  // Clear before set so a same-edge issue keeps the register busy for the
  // newer producer; flush overrides both.
  always_comb begin
    busy_next = busy;
    if (wr_active) begin
      busy_next[rd_sel_in] = 1'b0;
    end
    if (issue_accept && issue_rd_en && (issue_rd != '0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    if (flush) begin
      busy_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      busy <= busy_next;
      if (wr_active) begin
        regs[rd_sel_in] <= write_data_in;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: bypass and non-bypass instances driven in
// parallel, table-driven vectors plus reset and busy-timing sequences.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_sel, rs2_sel, issue_rd, rd_sel;
  logic        rs1_en, rs2_en, issue_valid, issue_rd_en, write_enable, flush;
  logic [31:0] wdata;
  logic [31:0] rs1_val, rs2_val, nb_rs1_val, nb_rs2_val;
  logic        rs1_busy, rs2_busy, ready, nb_rs1_busy, nb_rs2_busy, nb_ready;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_sel_in(rs1_sel), .rs2_sel_in(rs2_sel), .rs1_en(rs1_en), .rs2_en(rs2_en),
    .rs1_value_out(rs1_val), .rs2_value_out(rs2_val),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_valid(issue_valid), .issue_rd_en(issue_rd_en), .issue_rd(issue_rd),
    .issue_ready(ready), .write_enable(write_enable), .rd_sel_in(rd_sel),
    .write_data_in(wdata), .flush(flush)
  );

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n),
    .rs1_sel_in(rs1_sel), .rs2_sel_in(rs2_sel), .rs1_en(rs1_en), .rs2_en(rs2_en),
    .rs1_value_out(nb_rs1_val), .rs2_value_out(nb_rs2_val),
    .rs1_busy(nb_rs1_busy), .rs2_busy(nb_rs2_busy),
    .issue_valid(issue_valid), .issue_rd_en(issue_rd_en), .issue_rd(issue_rd),
    .issue_ready(nb_ready), .write_enable(write_enable), .rd_sel_in(rd_sel),
    .write_data_in(wdata), .flush(flush)
  );

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } chk_t;

  chk_t chk_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      0:       return rs1_val;
      1:       return rs2_val;
      2:       return {31'b0, rs1_busy};
      3:       return {31'b0, rs2_busy};
      4:       return {31'b0, ready};
      5:       return nb_rs2_val;
      6:       return {31'b0, nb_rs1_busy};
      default: return {31'b0, nb_ready};
    endcase
  endfunction

  task automatic expect_val(input string name, input int sig, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.sig  = sig;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic check_all();
    chk_t c;
    logic [31:0] a;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      a = actual(c.sig);
      total++;
      if (a !== c.exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h at %0t", c.name, a, c.exp, $time);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_sel = '0; rs2_sel = '0; rs1_en = 1'b0; rs2_en = 1'b0;
    issue_valid = 1'b0; issue_rd_en = 1'b0; issue_rd = '0;
    write_enable = 1'b0; rd_sel = '0; wdata = '0; flush = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  r1, r2;
    logic        e1, e2, iv, ie;
    logic [4:0]  ird;
    logic        fl;
    logic [31:0] x1, x2;
    logic        b1, b2, rdy;
    logic [31:0] nb2;
  } vec_t;

  function automatic vec_t mk(
    input logic we, input logic [4:0] rd, input logic [31:0] wd,
    input logic [4:0] r1, input logic [4:0] r2, input logic e1, input logic e2,
    input logic iv, input logic ie, input logic [4:0] ird, input logic fl,
    input logic [31:0] x1, input logic [31:0] x2,
    input logic b1, input logic b2, input logic rdy, input logic [31:0] nb2);
    vec_t v;
    v.we = we; v.rd = rd; v.wd = wd; v.r1 = r1; v.r2 = r2; v.e1 = e1; v.e2 = e2;
    v.iv = iv; v.ie = ie; v.ird = ird; v.fl = fl; v.x1 = x1; v.x2 = x2;
    v.b1 = b1; v.b2 = b2; v.rdy = rdy; v.nb2 = nb2;
    return v;
  endfunction

  vec_t vecs[20];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                we  rd   wdata        r1  r2  e1 e2 iv ie ird fl  x1           x2           b1 b2 rdy nb2
    vecs[0]  = mk(1, 5,  32'hDEADBEEF, 5,  0,  0, 0, 0, 0, 0,  0, 32'hDEADBEEF, 32'h0,       0, 0, 1, 32'h0);
    vecs[1]  = mk(0, 0,  32'h0,        5,  5,  0, 0, 0, 0, 0,  0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF);
    vecs[2]  = mk(1, 0,  32'h12345678, 0,  0,  0, 0, 1, 1, 0,  0, 32'h0,       32'h0,       0, 0, 1, 32'h0);
    vecs[3]  = mk(0, 0,  32'h0,        0,  0,  1, 0, 1, 1, 0,  0, 32'h0,       32'h0,       0, 0, 1, 32'h0);
    vecs[4]  = mk(1, 7,  32'hA5A5A5A5, 0,  7,  0, 0, 0, 0, 0,  0, 32'h0,       32'hA5A5A5A5, 0, 0, 1, 32'h0);
    vecs[5]  = mk(0, 0,  32'h0,        0,  7,  0, 0, 0, 0, 0,  0, 32'h0,       32'hA5A5A5A5, 0, 0, 1, 32'hA5A5A5A5);
    vecs[6]  = mk(0, 0,  32'h0,        3,  0,  0, 0, 1, 1, 3,  0, 32'h0,       32'h0,       0, 0, 1, 32'h0);
    vecs[7]  = mk(0, 0,  32'h0,        3,  0,  1, 0, 1, 0, 0,  0, 32'h0,       32'h0,       1, 0, 0, 32'h0);
    vecs[8]  = mk(1, 3,  32'h42,       3,  0,  1, 0, 1, 0, 0,  0, 32'h42,      32'h0,       0, 0, 1, 32'h0);
    vecs[9]  = mk(0, 0,  32'h0,        3,  3,  1, 0, 0, 0, 0,  0, 32'h42,      32'h42,      0, 0, 1, 32'h42);
    vecs[10] = mk(0, 0,  32'h0,        9,  0,  0, 0, 1, 1, 9,  0, 32'h0,       32'h0,       0, 0, 1, 32'h0);
    vecs[11] = mk(1, 9,  32'h77,       9,  9,  0, 0, 1, 1, 9,  0, 32'h77,      32'h77,      0, 0, 1, 32'h0);
    vecs[12] = mk(0, 0,  32'h0,        9,  9,  1, 0, 0, 0, 0,  0, 32'h77,      32'h77,      1, 1, 0, 32'h77);
    vecs[13] = mk(0, 0,  32'h0,        9,  0,  0, 0, 1, 1, 9,  0, 32'h77,      32'h0,       1, 0, 0, 32'h0);
    vecs[14] = mk(0, 0,  32'h0,        0,  0,  0, 0, 1, 1, 1,  0, 32'h0,       32'h0,       0, 0, 1, 32'h0);
    vecs[15] = mk(0, 0,  32'h0,        0,  0,  0, 0, 1, 1, 2,  0, 32'h0,       32'h0,       0, 0, 1, 32'h0);
    vecs[16] = mk(0, 0,  32'h0,        0,  0,  0, 0, 1, 1, 31, 0, 32'h0,       32'h0,       0, 0, 1, 32'h0);
    vecs[17] = mk(1, 20, 32'hCAFE,     1,  31, 0, 0, 1, 1, 4,  1, 32'h0,       32'h0,       1, 1, 0, 32'h0);
    vecs[18] = mk(0, 0,  32'h0,        2,  4,  1, 1, 0, 0, 0,  0, 32'h0,       32'h0,       0, 0, 1, 32'h0);
    vecs[19] = mk(0, 0,  32'h0,        9,  20, 0, 0, 0, 1, 31, 0, 32'h77,      32'hCAFE,    0, 0, 1, 32'hCAFE);

    idle();
    rst_n = 1'b0;
    #2;
    expect_val("reset_rs1_val", 0, 32'h0);
    expect_val("reset_rs1_busy", 2, 32'h0);
    expect_val("reset_ready", 4, 32'h1);
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      write_enable = vecs[i].we; rd_sel = vecs[i].rd; wdata = vecs[i].wd;
      rs1_sel = vecs[i].r1; rs2_sel = vecs[i].r2;
      rs1_en = vecs[i].e1; rs2_en = vecs[i].e2;
      issue_valid = vecs[i].iv; issue_rd_en = vecs[i].ie; issue_rd = vecs[i].ird;
      flush = vecs[i].fl;
      expect_val($sformatf("v%0d_rs1_val", i), 0, vecs[i].x1);
      expect_val($sformatf("v%0d_rs2_val", i), 1, vecs[i].x2);
      expect_val($sformatf("v%0d_rs1_busy", i), 2, {31'b0, vecs[i].b1});
      expect_val($sformatf("v%0d_rs2_busy", i), 3, {31'b0, vecs[i].b2});
      expect_val($sformatf("v%0d_ready", i), 4, {31'b0, vecs[i].rdy});
      expect_val($sformatf("v%0d_nb_rs2_val", i), 5, vecs[i].nb2);
      cycle();
    end

    // Asynchronous reset mid-run with x5 holding data and busy.
    idle();
    rs1_sel = 5; rs2_sel = 5; issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 5;
    expect_val("pre_rst_ready", 4, 32'h1);
    cycle();
    idle();
    rs1_sel = 5; rs2_sel = 5;
    @(negedge clk);
    expect_val("pre_rst_val", 0, 32'hDEADBEEF);
    expect_val("pre_rst_busy", 2, 32'h1);
    check_all();
    #1 rst_n = 1'b0;
    #1;
    expect_val("async_rst_val", 0, 32'h0);
    expect_val("async_rst_nb_val", 5, 32'h0);
    expect_val("async_rst_busy", 2, 32'h0);
    expect_val("async_rst_ready", 4, 32'h1);
    check_all();
    flush = 1'b1;
    #1;
    expect_val("rst_flush_ready", 4, 32'h0);
    check_all();
    flush = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    expect_val("post_rst_val", 0, 32'h0);
    expect_val("post_rst_busy", 2, 32'h0);
    cycle();

    // Busy exemption timing with and without bypass.
    idle();
    rs1_sel = 6; issue_valid = 1'b1; issue_rd_en = 1'b1; issue_rd = 6;
    expect_val("b6_ready", 4, 32'h1);
    expect_val("b6_nb_ready", 7, 32'h1);
    cycle();
    write_enable = 1'b1; rd_sel = 6; wdata = 32'h66; rs1_en = 1'b1;
    expect_val("b6_wb_busy", 2, 32'h0);
    expect_val("b6_wb_nb_busy", 6, 32'h1);
    expect_val("b6_wb_val", 0, 32'h66);
    expect_val("b6_wb_ready", 4, 32'h1);
    expect_val("b6_wb_nb_ready", 7, 32'h0);
    cycle();
    idle();
    rs1_sel = 6;
    expect_val("b6_after_busy", 2, 32'h1);
    expect_val("b6_after_nb_busy", 6, 32'h0);
    expect_val("b6_after_val", 0, 32'h66);
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
